sorted_insert_writer: RTL and testbench

- Writer-side producer of the sorted array that the binary-search block consumes.
- Accepts one value at a time over a valid/ready handshake.
- Inserts each value into an external synchronous RAM in ascending order by shifting larger entries up one slot, so the RAM always holds a sorted prefix of length count.
- Built as a control FSM plus a small datapath: index register, value latch, read-data latch, and occupancy counter.

---
 rtl/sorted_insert_writer.sv | 104 ++++++++++
 tb/tb_sorted_insert_writer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sorted_insert_writer.sv
// Inserts values one at a time into an external synchronous RAM, keeping
// mem[0..count-1] sorted ascending by shifting larger entries up one slot.
module sorted_insert_writer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              clear,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              insert_done
);
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CMP   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_PLACE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d, i_m1;
  logic [DATA_W-1:0] value_q, value_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [ADDR_W:0]   count_q, count_d;

  assign i_m1     = i_q - 1'b1;
  assign count    = count_q;
  assign full     = (count_q == (ADDR_W+1)'(DEPTH));
  assign in_ready = (state_q == S_IDLE) && !full && !clear;

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    value_d     = value_q;
    rd_d        = rd_q;
    count_d     = count_q;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    insert_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        // clear takes priority; in_ready is already low while it is asserted
        if (clear) begin
          count_d = '0;
        end else if (in_valid && in_ready) begin
          value_d = in_data;
          i_d     = count_q[ADDR_W-1:0];
          state_d = (count_q == '0) ? S_PLACE : S_READ;
        end
      end
      S_READ: begin
        mem_addr = i_m1;
        state_d  = S_CMP;
      end
      S_CMP: begin
        rd_d    = mem_rdata;
        // strict compare keeps equal values in arrival order
        state_d = (mem_rdata > value_q) ? S_SHIFT : S_PLACE;
      end
      S_SHIFT: begin
        mem_addr  = i_q;
        mem_wdata = rd_q;
        mem_we    = 1'b1;
        i_d       = i_m1;
        state_d   = (i_m1 == '0) ? S_PLACE : S_READ;
      end
      S_PLACE: begin
        mem_addr    = i_q;
        mem_wdata   = value_q;
        mem_we      = 1'b1;
        insert_done = 1'b1;
        count_d     = count_q + 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      value_q <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      value_q <= value_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_sorted_insert_writer.sv
// Directed bench for sorted_insert_writer with a behavioural synchronous RAM
// and a sorted reference list of the values inserted so far.
module tb_sorted_insert_writer;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       clear;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic [5:0] count;
  logic       full;
  logic       insert_done;

  logic [7:0] mem [32];
  logic [7:0] model [$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  sorted_insert_writer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .clear(clear), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .count(count), .full(full), .insert_done(insert_done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inserts v and checks placement cycle, address, write count and contents.
  task automatic do_insert(input logic [7:0] v, input bit clr_mid);
    int n, k, pos, exp_cyc, cyc, writes;
    bit done;
    n = model.size();
    k = 0;
    foreach (model[j]) if (model[j] > v) k++;
    pos     = n - k;
    exp_cyc = 1 + 3 * k + ((k < n) ? 2 : 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    chk("accept_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (clr_mid) clear = 1'b1;
    cyc = 0; writes = 0; done = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mem_we) writes++;
      if (insert_done) begin
        done  = 1;
        clear = 1'b0;
      end
    end
    clear = 1'b0;
    chk("done_seen", done, 1);
    chk("place_cycle", cyc, exp_cyc);
    chk("place_addr", mem_addr, pos);
    chk("place_data", mem_wdata, v);
    chk("write_count", writes, k + 1);
    model.insert(pos, v);
    @(negedge clk);
    chk("ready_after", in_ready, (model.size() < 32) ? 1 : 0);
    chk("count_after", count, model.size());
    foreach (model[j]) chk("mem_contents", mem[j], model[j]);
    for (int j = 0; j + 1 < model.size(); j++)
      chk("sorted", (mem[j] <= mem[j+1]) ? 1 : 0, 1);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model.delete();
    chk("clear_count", count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    bit hit;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0;
    foreach (mem[j]) mem[j] = 8'hff;
    repeat (3) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_done", insert_done, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_full", full, 0);

    do_insert(8'd5, 0);
    do_insert(8'd9, 0);
    do_insert(8'd3, 0);
    do_insert(8'd7, 1);   // clear held during insertion must be ignored
    do_insert(8'd5, 0);
    chk("arr_3", mem[0], 3); chk("arr_5a", mem[1], 5); chk("arr_5b", mem[2], 5);
    chk("arr_7", mem[3], 7); chk("arr_9", mem[4], 9);

    // clear and in_valid together with count == 2
    do_clear();
    do_insert(8'd4, 0);
    do_insert(8'd6, 0);
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'd1;
    #1 chk("clr_vld_ready", in_ready, 0);
    chk("clr_vld_we", mem_we, 0);
    @(negedge clk);
    chk("clr_vld_we2", mem_we, 0);
    chk("clr_vld_done", insert_done, 0);
    chk("clr_vld_count", count, 0);
    clear = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("clr_vld_stay", count, 0);
    model.delete();

    // reset during S_SHIFT of an insert into a 3-entry array
    do_insert(8'd2, 0);
    do_insert(8'd4, 0);
    do_insert(8'd6, 0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0; hit = 0;
    while (!hit && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (mem_we && !insert_done) hit = 1;
    end
    chk("shift_seen", hit, 1);
    reset = 1'b0;
    #1 chk("midrst_we", mem_we, 0);
    chk("midrst_count", count, 0);
    @(negedge clk);
    reset = 1'b1;
    model.delete();
    @(negedge clk);
    chk("midrst_ready", in_ready, 1);
    do_insert(8'd8, 0);

    // fill descending: every insert shifts all entries (worst case on the last)
    do_clear();
    for (int v = 32; v >= 1; v--) do_insert(8'(v), 0);
    chk("full_flag", full, 1);
    chk("full_ready", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("full_no_write", mem_we, 0);
    end
    chk("full_count_hold", count, 32);
    in_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    chk("full_clr_count", count, 0);
    chk("full_clr_full", full, 0);
    clear = 1'b0;
    #1 chk("full_clr_ready", in_ready, 1);
    model.delete();
    do_insert(8'd42, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
